level_score_ctrl: RTL and testbench
===================================

// Module: level_score_ctrl
// PURPOSE
//  Game-flow controller fed by the point-collection stage. Consumes its capture_point pulse and captured[4:0] mask.
//  Keeps a 3-digit BCD score and drives lvl[2:0] back to the collector.
//  Advances the level once all 5 points are taken. Asserts level_clear so the top can OR it into the collector's reset.
// PARAMETERS
//  NUM_LEVELS     3            last playable level (lvl 1..NUM_LEVELS)
//  POINT_VALUE    12'h010      BCD score added per capture_point pulse
//  LEVEL_BONUS    12'h050      BCD score added once per cleared level
//  CLEAR_HOLD     16           cycles spent in CLEAR (>=2)
//  LEVEL_TIME     8'd60        seconds per level (timer option only)
//  TICKS_PER_SEC  100_000_000  clk cycles per second (timer option only)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset, asynchronous, active-high
//  start          in   1   1-cycle pulse, debounced start button
//  capture_point  in   1   1-cycle pulse, one point taken this cycle
//  captured       in   5   collector's captured-point mask
//  lvl            out  3   current level, 0 = no game
//  score_bcd      out  12  score, 3 BCD digits [11:8]=hundreds
//  level_clear    out  1   high for all of CLEAR; clears collector
//  game_won       out  1   high in WON
//  time_left      out  8   seconds remaining (0 without timer option)
//  game_over      out  1   high in LOST (0 without timer option)
// BEHAVIOUR
//  - All outputs registered. On rst: state=IDLE, lvl=0, score=0, counters=0, level_clear/game_won/game_over=0.
//  - rst mid-game aborts to IDLE immediately.
//  - IDLE: start -> PLAY, lvl=1, score=0.
//  - PLAY:
//    - capture_point=1 -> score += POINT_VALUE on the next edge.
//    - captured==5'h1F -> CLEAR on the next edge. A point pulse in the same cycle is still scored.
//    - start is ignored.
//  - CLEAR:
//    - level_clear=1 for exactly CLEAR_HOLD cycles. LEVEL_BONUS is added once, on the first CLEAR cycle.
//    - capture_point and captured are ignored.
//    - On exit: if lvl==NUM_LEVELS -> WON with lvl held; else lvl+1 -> PLAY.
//  - WON: game_won=1. start -> PLAY, lvl=1, score=0.
//  - Score arithmetic: per-digit BCD add with decimal carry.
//    - Saturates at 12'h999; no wrap.
//    - Digits are never outside 0-9.
//  - Latency: capture_point at edge N -> score updated at edge N+1.
//  - captured==1F seen at edge N -> level_clear=1 from edge N+1.
//  - lvl values other than 0..NUM_LEVELS never occur.
// CONFIGURATION
//  LEVEL_TIMER_EN defined:
//    - time_left loads LEVEL_TIME on every entry to PLAY.
//    - A prescaler counts TICKS_PER_SEC clk cycles and decrements time_left once per second in PLAY.
//    - Prescaler and time_left freeze in CLEAR/WON and reset on entry to PLAY.
//    - time_left reaching 0 in PLAY -> LOST: game_over=1, lvl held, score frozen.
//    - captured==1F and the timeout in the same cycle: CLEAR wins.
//    - LOST + start -> PLAY, lvl=1, score=0.
//  LEVEL_TIMER_EN undefined:
//    - No prescaler, no LOST state.
//    - time_left=0, game_over=0 constantly.
// TESTING
//  1 rst; start pulse -> lvl=1, score=000.
//    Then 3 capture_point pulses -> score=030, one edge after each pulse.
//  2 lvl=1, captured stepped to 1F with 5 pulses
//    -> score=050+050=100; level_clear high exactly 16 cycles; then lvl=2.
//  3 Clear all 3 levels -> after the third CLEAR, game_won=1, lvl=3, score=(50+50)*3=300.
//    Then start -> lvl=1, score=000.
//  4 Preload score 990 (POINT_VALUE=12'h010 pulses); one more pulse
//    -> score=999 (saturated); another pulse -> stays 999.
//  5 Assert rst mid-CLEAR -> same cycle: level_clear=0, lvl=0, score=000.
//    capture_point while in IDLE -> no change.
//  6 LEVEL_TIMER_EN, TICKS_PER_SEC=4, LEVEL_TIME=3, no captures
//    -> time_left 3,2,1,0 every 4 cycles; game_over=1, lvl held.
//    Repeat with captured=1F on the timeout cycle -> level_clear=1, game_over=0.

Source files
------------

// File: rtl/level_score_ctrl.sv
// level_score_ctrl: game-flow controller for the point-collection game.
// Tracks the level (1..NUM_LEVELS), keeps a saturating 3-digit BCD score and
// pulses level_clear_o for CLEAR_HOLD cycles so the top can reset the collector.
// Optional feature macro: LEVEL_TIMER_EN adds a per-level countdown timer with
// a LOST state; without it time_left_o and game_over_o are constant zero.
module level_score_ctrl #(
  parameter int unsigned NUM_LEVELS    = 3,
  parameter logic [11:0] POINT_VALUE   = 12'h010,
  parameter logic [11:0] LEVEL_BONUS   = 12'h050,
  parameter int unsigned CLEAR_HOLD    = 16,
  parameter logic [7:0]  LEVEL_TIME    = 8'd60,
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        capture_point_i,
  input  logic [4:0]  captured_i,
  output logic [2:0]  lvl_o,
  output logic [11:0] score_bcd_o,
  output logic        level_clear_o,
  output logic        game_won_o,
  output logic [7:0]  time_left_o,
  output logic        game_over_o
);

  localparam int unsigned CNT_W = $clog2(CLEAR_HOLD);
  localparam logic [4:0]  ALL_CAPTURED = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CLEAR = 3'd2,
    S_WON   = 3'd3
`ifdef LEVEL_TIMER_EN
    , S_LOST = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         lvl_q, lvl_d;
  logic [11:0]        score_q, score_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               level_clear_q, level_clear_d;
  logic               game_won_q, game_won_d;

`ifdef LEVEL_TIMER_EN
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  logic [PW-1:0]      presc_q, presc_d;
  logic [7:0]         time_left_q, time_left_d;
  logic               game_over_q, game_over_d;
`endif

  // Saturating per-digit BCD add; a carry out of the hundreds digit pins 999.
  function automatic logic [11:0] bcd_sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] sum;
    logic [4:0]  dig;
    logic        carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dig = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
      if (dig > 5'd9) begin
        dig   = dig - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dig[3:0];
    end
    return carry ? 12'h999 : sum;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lvl_q         <= 3'd0;
      score_q       <= 12'h000;
      clr_cnt_q     <= '0;
      level_clear_q <= 1'b0;
      game_won_q    <= 1'b0;
`ifdef LEVEL_TIMER_EN
      presc_q       <= '0;
      time_left_q   <= 8'd0;
      game_over_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      score_q       <= score_d;
      clr_cnt_q     <= clr_cnt_d;
      level_clear_q <= level_clear_d;
      game_won_q    <= game_won_d;
`ifdef LEVEL_TIMER_EN
      presc_q       <= presc_d;
      time_left_q   <= time_left_d;
      game_over_q   <= game_over_d;
`endif
    end
  end

  // Next-state, score and flag logic.
  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    score_d       = score_q;
    clr_cnt_d     = clr_cnt_q;
    level_clear_d = 1'b0;
    game_won_d    = 1'b0;
`ifdef LEVEL_TIMER_EN
    presc_d       = presc_q;
    time_left_d   = time_left_q;
    game_over_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_PLAY;
          lvl_d   = 3'd1;
          score_d = 12'h000;
`ifdef LEVEL_TIMER_EN
          presc_d     = '0;
          time_left_d = LEVEL_TIME;
`endif
        end
      end

      S_PLAY: begin
        if (capture_point_i) begin
          score_d = bcd_sat_add(score_q, POINT_VALUE);
        end
        // Clearing the level takes priority over a simultaneous timeout.
        if (captured_i == ALL_CAPTURED) begin
          state_d       = S_CLEAR;
          clr_cnt_d     = '0;
          level_clear_d = 1'b1;
        end
`ifdef LEVEL_TIMER_EN
        else if (time_left_q == 8'd0) begin
          state_d     = S_LOST;
          game_over_d = 1'b1;
        end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
          presc_d     = '0;
          time_left_d = time_left_q - 8'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
`endif
      end

      S_CLEAR: begin
        if (clr_cnt_q == '0) begin
          score_d = bcd_sat_add(score_q, LEVEL_BONUS);
        end
        if (clr_cnt_q == CNT_W'(CLEAR_HOLD - 1)) begin
          if (lvl_q == 3'(NUM_LEVELS)) begin
            state_d    = S_WON;
            game_won_d = 1'b1;
          end else begin
            state_d = S_PLAY;
            lvl_d   = lvl_q + 3'd1;
`ifdef LEVEL_TIMER_EN
            presc_d     = '0;
            time_left_d = LEVEL_TIME;
`endif
          end
        end else begin
          clr_cnt_d     = clr_cnt_q + CNT_W'(1);
          level_clear_d = 1'b1;
        end
      end

      S_WON: begin
        game_won_d = 1'b1;
        if (start_i) begin
          state_d    = S_PLAY;
          lvl_d      = 3'd1;
          score_d    = 12'h000;
          game_won_d = 1'b0;
`ifdef LEVEL_TIMER_EN
          presc_d     = '0;
          time_left_d = LEVEL_TIME;
`endif
        end
      end

`ifdef LEVEL_TIMER_EN
      S_LOST: begin
        game_over_d = 1'b1;
        if (start_i) begin
          state_d     = S_PLAY;
          lvl_d       = 3'd1;
          score_d     = 12'h000;
          game_over_d = 1'b0;
          presc_d     = '0;
          time_left_d = LEVEL_TIME;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        lvl_d   = 3'd0;
        score_d = 12'h000;
      end
    endcase
  end

  assign lvl_o         = lvl_q;
  assign score_bcd_o   = score_q;
  assign level_clear_o = level_clear_q;
  assign game_won_o    = game_won_q;

`ifdef LEVEL_TIMER_EN
  assign time_left_o = time_left_q;
  assign game_over_o = game_over_q;
`else
  // Timer parameters only matter when the timer is built in.
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{LEVEL_TIME, 32'(TICKS_PER_SEC)};
  assign time_left_o = 8'd0;
  assign game_over_o = 1'b0;
`endif

endmodule

// File: tb/tb_level_score_ctrl.sv
// tb_level_score_ctrl: directed bench with a decimal-arithmetic game model
// compared against the DUT every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_level_score_ctrl;

`ifdef LEVEL_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam int TPS   = 4;
  localparam int LTIME = 3;
  localparam int HOLD  = 16;
  localparam int NLVL  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        capture_point = 1'b0;
  logic [4:0]  captured = 5'h00;
  logic [2:0]  lvl;
  logic [11:0] score_bcd;
  logic        level_clear;
  logic        game_won;
  logic [7:0]  time_left;
  logic        game_over;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  level_score_ctrl #(
    .TICKS_PER_SEC(TPS),
    .LEVEL_TIME(8'(LTIME))
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .capture_point_i(capture_point),
    .captured_i(captured),
    .lvl_o(lvl),
    .score_bcd_o(score_bcd),
    .level_clear_o(level_clear),
    .game_won_o(game_won),
    .time_left_o(time_left),
    .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (decimal score, mode strings) ----------
  string m_mode = "idle";
  int    m_lvl = 0;
  int    m_score = 0;
  int    m_clear_left = 0;
  bit    m_bonus_due = 0;
  int    m_time = 0;
  int    m_ticks = 0;

  function automatic int add_sat(input int s, input int v);
    return (s + v > 999) ? 999 : s + v;
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_new_level(input int l);
    m_mode  = "play";
    m_lvl   = l;
    m_time  = TIMER ? LTIME : 0;
    m_ticks = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = "idle"; m_lvl = 0; m_score = 0; m_clear_left = 0;
      m_bonus_due = 0; m_time = 0; m_ticks = 0;
    end else if (m_mode == "idle" || m_mode == "won" || m_mode == "lost") begin
      if (start) begin
        m_score = 0;
        model_new_level(1);
      end
    end else if (m_mode == "play") begin
      if (capture_point) m_score = add_sat(m_score, 10);
      if (captured == 5'h1F) begin
        m_mode = "clear"; m_clear_left = HOLD; m_bonus_due = 1;
      end else if (TIMER && m_time == 0) begin
        m_mode = "lost";
      end else if (TIMER) begin
        m_ticks++;
        if (m_ticks == TPS) begin m_ticks = 0; m_time--; end
      end
    end else if (m_mode == "clear") begin
      if (m_bonus_due) begin m_score = add_sat(m_score, 50); m_bonus_due = 0; end
      if (m_clear_left == 1) begin
        if (m_lvl == NLVL) m_mode = "won";
        else model_new_level(m_lvl + 1);
      end else begin
        m_clear_left--;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("cyc_lvl",         12'(lvl),         12'(m_lvl));
      chk("cyc_score",       score_bcd,        to_bcd(m_score));
      chk("cyc_level_clear", 12'(level_clear), 12'(m_mode == "clear"));
      chk("cyc_game_won",    12'(game_won),    12'(m_mode == "won"));
      chk("cyc_time_left",   12'(time_left),   12'(m_time));
      chk("cyc_game_over",   12'(game_over),   12'(m_mode == "lost"));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_point();
    @(negedge clk) capture_point = 1'b1;
    @(negedge clk) capture_point = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Step captured to 1F with a point pulse each step; count level_clear cycles.
  task automatic clear_level(output int hi_cnt);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      captured      = captured | 5'(1 << k);
      capture_point = 1'b1;
    end
    @(negedge clk);
    capture_point = 1'b0;
    captured      = 5'h00;
    hi_cnt = 0;
    for (int c = 0; c < 3 * HOLD; c++) begin
      if (level_clear) hi_cnt++;
      else if (hi_cnt > 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    #1 rst = 1'b1;
    #2;
    chk("rst_lvl",   12'(lvl),         12'h000);
    chk("rst_score", score_bcd,        12'h000);
    chk("rst_clear", 12'(level_clear), 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: start and three points
    pulse_start();
    chk("t1_lvl",   12'(lvl), 12'h001);
    chk("t1_score", score_bcd, 12'h000);
    for (int k = 1; k <= 3; k++) begin
      pulse_point();
      chk("t1_point_score", score_bcd, 12'(k * 16));
    end

    // 2: clear level 1 from a fresh game
    do_reset();
    pulse_start();
    clear_level(hi);
    chk("t2_clear_cycles", 12'(hi), 12'd16);
    chk("t2_score", score_bcd, 12'h100);
    chk("t2_lvl",   12'(lvl), 12'h002);

    // 3: clear levels 2 and 3 -> won, then restart
    clear_level(hi);
    chk("t3_clear_cycles_l2", 12'(hi), 12'd16);
    clear_level(hi);
    chk("t3_won",   12'(game_won), 12'h001);
    chk("t3_lvl",   12'(lvl), 12'h003);
    chk("t3_score", score_bcd, 12'h300);
    repeat (3) @(negedge clk);
    chk("t3_won_hold", 12'(game_won), 12'h001);
    pulse_start();
    chk("t3_restart_lvl",   12'(lvl), 12'h001);
    chk("t3_restart_score", score_bcd, 12'h000);

    // 4: saturation at 999
    @(negedge clk) capture_point = 1'b1;
    repeat (99) @(negedge clk);
    capture_point = 1'b0;
    chk("t4_preload", score_bcd, 12'h990);
    pulse_point();
    chk("t4_sat", score_bcd, 12'h999);
    pulse_point();
    chk("t4_sat_hold", score_bcd, 12'h999);

    // 5: reset in the middle of CLEAR, then points in IDLE
    @(negedge clk) captured = 5'h1F;
    repeat (3) @(negedge clk);
    captured = 5'h00;
    chk("t5_in_clear", 12'(level_clear), 12'h001);
    rst = 1'b1;
    #1;
    chk("t5_rst_clear", 12'(level_clear), 12'h000);
    chk("t5_rst_lvl",   12'(lvl), 12'h000);
    chk("t5_rst_score", score_bcd, 12'h000);
    @(negedge clk) rst = 1'b0;
    pulse_point();
    chk("t5_idle_score", score_bcd, 12'h000);
    chk("t5_idle_lvl",   12'(lvl), 12'h000);

`ifdef LEVEL_TIMER_EN
    // 6: countdown to LOST, then a clear on the timeout cycle
    pulse_start();
    chk("t6_time3", 12'(time_left), 12'd3);
    repeat (4) @(negedge clk);
    chk("t6_time2", 12'(time_left), 12'd2);
    repeat (4) @(negedge clk);
    chk("t6_time1", 12'(time_left), 12'd1);
    repeat (4) @(negedge clk);
    chk("t6_time0", 12'(time_left), 12'd0);
    @(negedge clk);
    chk("t6_over", 12'(game_over), 12'h001);
    chk("t6_lvl_held", 12'(lvl), 12'h001);
    pulse_start();
    chk("t6_restart_time", 12'(time_left), 12'd3);
    repeat (12) @(negedge clk);
    captured = 5'h1F;
    @(negedge clk);
    captured = 5'h00;
    chk("t6_race_clear", 12'(level_clear), 12'h001);
    chk("t6_race_over",  12'(game_over), 12'h000);
    repeat (HOLD + 4) @(negedge clk);
    chk("t6_next_lvl",  12'(lvl), 12'h002);
    chk("t6_next_time", 12'(time_left), 12'd3);
`else
    pulse_start();
    repeat (20) @(negedge clk);
    chk("t6_no_timer_time", 12'(time_left), 12'd0);
    chk("t6_no_timer_over", 12'(game_over), 12'h000);
`endif

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
